// File: rtl/note_scheduler.sv
// Last-note-priority keyboard scanner that offers {gate, note, octave} updates to a tone generator.
// Optional NOTE_HOLD_EN adds a sustain input that keeps the last note sounding after all keys are released.
module note_scheduler #(
    parameter int TICK_COUNT = 250000,
    parameter int SCALE_MIN  = 1,
    parameter int SCALE_MAX  = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] keys,
    input  logic [7:0] scale,
`ifdef NOTE_HOLD_EN
    input  logic       hold,
`endif
    input  logic       cfg_ready,
    output logic       cfg_valid,
    output logic       cfg_gate,
    output logic [2:0] cfg_note,
    output logic [2:0] cfg_octave,
    output logic [7:0] active_led
);

    localparam int            CW        = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_COUNT - 1);
    localparam logic [7:0]    SMIN8     = 8'(SCALE_MIN);
    localparam logic [7:0]    SMAX8     = 8'(SCALE_MAX);
    localparam logic [2:0]    SMIN3     = 3'(SCALE_MIN);
    localparam logic [2:0]    SMAX3     = 3'(SCALE_MAX);

    // Handshake: the payload is offered while cfg_valid=1 and stays frozen until a
    // rising edge sees cfg_valid & cfg_ready; that edge is the transfer.
    typedef enum logic {IDLE, SEND} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] tick_cnt;
    logic          tick;
    logic [7:0]    keys_meta, keys_sync;
    logic [7:0]    pressed, prev_pressed, next_pressed, new_press;
    logic [2:0]    cur_key;
    logic          any_held, gate_d;
    logic [2:0]    octave_d;
    logic [6:0]    desired, payload, last_sent;
    logic          load, accept;

    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        lowest_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lowest_idx = 3'(i);
        end
    endfunction

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            keys_meta <= 8'd0;
            keys_sync <= 8'd0;
        end else begin
            keys_meta <= keys;
            keys_sync <= keys_meta;
        end
    end

    // New presses are judged against the sample being replaced, so cur_key moves on the same tick edge.
    always_comb begin
        next_pressed = ~keys_sync;
        new_press    = next_pressed & ~pressed;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pressed      <= 8'd0;
            prev_pressed <= 8'd0;
            cur_key      <= 3'd0;
        end else if (tick) begin
            pressed      <= next_pressed;
            prev_pressed <= pressed;
            if (|new_press) begin
                cur_key <= lowest_idx(new_press);
            end else if ((|next_pressed) && !next_pressed[cur_key]) begin
                cur_key <= lowest_idx(next_pressed);
            end
        end
    end

    assign any_held = |pressed;

`ifdef NOTE_HOLD_EN
    logic sustain;

    // sustain remembers that a note was sounding, so hold alone never starts one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sustain <= 1'b0;
        end else begin
            sustain <= gate_d;
        end
    end

    assign gate_d = any_held | (hold & sustain);
`else
    assign gate_d = any_held;
`endif

    always_comb begin
        octave_d = scale[2:0];
        if (scale < SMIN8) begin
            octave_d = SMIN3;
        end else if (scale > SMAX8) begin
            octave_d = SMAX3;
        end
        desired = gate_d ? {1'b1, cur_key, octave_d} : 7'd0;
    end

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        accept    = 1'b0;
        cfg_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (desired != last_sent) begin
                    load    = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                cfg_valid = 1'b1;
                if (cfg_ready) begin
                    accept  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            payload   <= 7'd0;
            last_sent <= 7'd0;
        end else begin
            state_q <= state_d;
            if (load)   payload   <= desired;
            if (accept) last_sent <= payload;
        end
    end

    assign cfg_gate   = payload[6];
    assign cfg_note   = payload[5:3];
    assign cfg_octave = payload[2:0];
    assign active_led = last_sent[6] ? (8'd1 << last_sent[5:3]) : 8'd0;

endmodule

// File: doc/note_scheduler.md
NOTE_SCHEDULER -- requirements
Module: note_scheduler

Interface
REQ-001 Parameter TICK_COUNT, default 250000, key-sampling period in clk cycles (5 ms at 50 MHz).
REQ-002 Parameter SCALE_MIN, default 1, lowest legal octave.
REQ-003 Parameter SCALE_MAX, default 5, highest legal octave.
REQ-004 Port clk  input  1  sole clock, all state on rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port keys  input  8  piano keys, active-low (0 = pressed), asynchronous to clk.
REQ-007 Port scale  input  8  octave from the octave selector, synchronous to clk.
REQ-008 Port cfg_ready  input  1  tone generator accepts a configuration.
REQ-009 Port cfg_valid  output  1  configuration offered to the tone generator.
REQ-010 Port cfg_gate  output  1  1 = sound note, 0 = silence.
REQ-011 Port cfg_note  output  3  key index 0..7 to play.
REQ-012 Port cfg_octave  output  3  octave to play.
REQ-013 Port active_led  output  8  one-hot of the key currently sounding.

Function
REQ-014 Tick counter counts 0..TICK_COUNT-1 and wraps; tick is the cycle where the count equals TICK_COUNT-1.
REQ-015 keys synchronised through two flops; on tick only, pressed[7:0] <= ~synchronised keys; prev_pressed <= old pressed.
REQ-016 New presses = pressed & ~prev_pressed; among simultaneous new presses, lowest index wins and becomes cur_key.
REQ-017 Newest press always pre-empts a currently sounding key (last-note priority).
REQ-018 cur_key released while other keys held: cur_key <= lowest-index held key, same update cycle.
REQ-019 No key held: desired gate = 0, desired note = 0, desired octave = 0.
REQ-020 Gate on: desired octave = scale clamped to SCALE_MIN..SCALE_MAX (scale 0 -> 1, scale 9 -> 5); desired note = cur_key.
REQ-021 FSM states IDLE, SEND.
REQ-022 IDLE: desired tuple {gate,note,octave} != last-sent tuple -> load payload registers, go SEND next cycle (1-cycle latency from desired change to cfg_valid=1).
REQ-023 SEND: cfg_valid=1, payload frozen until cfg_valid & cfg_ready at a rising edge; then last-sent <= payload, go IDLE.
REQ-024 cfg_ready ignored in IDLE; cfg_ready held high gives one transfer per two cycles at most.
REQ-025 Desired changes during SEND are not lost: re-evaluated in IDLE after the transfer; intermediate values may be skipped, final value always sent.
REQ-026 Scale change while gate=1 triggers an update; while gate=0 it does not.
REQ-027 active_led = one-hot(cfg_note) when last-sent gate = 1, else 0; follows accepted transfers only.

Reset
REQ-028 reset asynchronously forces: tick counter 0, pressed/prev_pressed/synchronisers 0, cur_key 0, last-sent tuple 0, FSM IDLE.
REQ-029 Outputs during and after reset: cfg_valid 0, cfg_gate 0, cfg_note 0, cfg_octave 0, active_led 0.
REQ-030 Reset mid-SEND abandons the offer; no transfer is counted; no update is sent after release unless a key is pressed.

Configuration
REQ-031 Macro NOTE_HOLD_EN defined: adds port hold  input  1 (synchronous, active-high).
REQ-032 With NOTE_HOLD_EN, while hold=1 and all keys released, gate stays 1 with the last cur_key; hold falling with no key held -> desired gate 0 at the next cycle.
REQ-033 Without NOTE_HOLD_EN, port hold does not exist; behaviour equals hold=0.

Verification (bench uses TICK_COUNT=4)
REQ-034 Reset, keys=8'hFF, cfg_ready=1 for 100 cycles -> cfg_valid never 1, all outputs 0.
REQ-035 keys=8'hFB, scale=3, cfg_ready=1 -> one transfer gate=1 note=2 octave=3, active_led=8'h04.
REQ-036 Hold key 2, then add key 6 (keys=8'hBB) -> transfer note=6; release key 6 -> transfer note=2.
REQ-037 Key 1 held, cfg_ready=0, scale 2->4->5 during SEND -> payload frozen at octave 2; raise cfg_ready -> octave 2 accepted, then octave 5 sent, octave 4 never.
REQ-038 keys=8'h7E (keys 0 and 7 new together) -> note=0; scale=0 -> octave 1; scale=9 -> octave 5.
REQ-039 NOTE_HOLD_EN: key 3 held, hold=1, release key 3 -> no transfer; hold=0 -> transfer gate=0 note=0 octave=0, active_led=0.
